// File: rtl/fpu_axis_issuer.sv
// Ready/valid front end for a fixed-latency FP16 add/sub pipe: issues operands, tracks in-flight ops,
// buffers results in a FWFT FIFO. Define ISSUER_STATS_EN to add the stat_issued / stat_exc counters.
module fpu_axis_issuer #(
  parameter int LATENCY    = 6,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 16
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic [2*DATA_W-1:0] s_axis_op_tdata,
  input  logic                s_axis_op_tvalid,
  output logic                s_axis_op_tready,
  output logic [DATA_W-1:0]   fpu_a_tdata,
  output logic [DATA_W-1:0]   fpu_b_tdata,
  output logic                fpu_a_tvalid,
  output logic                fpu_b_tvalid,
  input  logic [DATA_W-1:0]   fpu_result_tdata,
  input  logic                fpu_result_tvalid,
  output logic [DATA_W-1:0]   m_axis_res_tdata,
  output logic                m_axis_res_tuser,
  output logic                m_axis_res_tvalid,
  input  logic                m_axis_res_tready
`ifdef ISSUER_STATS_EN
  ,
  output logic [15:0]         stat_issued,
  output logic [15:0]         stat_exc
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int IF_W  = $clog2(LATENCY + 1);
  localparam int SUM_W = CNT_W + IF_W;

  logic               tready_q, tready_d;
  logic [LATENCY-1:0] track_q, track_d;
  logic [IF_W-1:0]    inflight_q, inflight_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W:0]    fifo_mem_q [FIFO_DEPTH];

  logic fire;
  logic capture;
  logic pop;
  logic res_valid;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fire      = s_axis_op_tvalid & tready_q;
  assign capture   = track_q[LATENCY-1];
  assign res_valid = (count_q != '0);
  assign pop       = res_valid & m_axis_res_tready;

  assign s_axis_op_tready = tready_q;
  assign fpu_a_tdata      = s_axis_op_tdata[2*DATA_W-1:DATA_W];
  assign fpu_b_tdata      = s_axis_op_tdata[DATA_W-1:0];
  assign fpu_a_tvalid     = fire;
  assign fpu_b_tvalid     = fire;

  // Output is forced to zero while empty so stale RAM contents never leak out.
  assign m_axis_res_tvalid = res_valid;
  assign {m_axis_res_tuser, m_axis_res_tdata} = res_valid ? fifo_mem_q[rd_ptr_q] : '0;

  always_comb begin
    track_d    = track_q << 1;
    track_d[0] = fire;

    inflight_d = inflight_q;
    if (fire && !capture) begin
      inflight_d = inflight_q + IF_W'(1);
    end else if (!fire && capture) begin
      inflight_d = inflight_q - IF_W'(1);
    end

    count_d = count_q;
    if (capture && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!capture && pop) begin
      count_d = count_q - CNT_W'(1);
    end

    wr_ptr_d = capture ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    // Every op in flight owns a FIFO slot, so a full FIFO can never be written.
    tready_d = (SUM_W'(count_d) + SUM_W'(inflight_d)) < SUM_W'(FIFO_DEPTH);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      tready_q   <= 1'b0;
      track_q    <= '0;
      inflight_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      tready_q   <= tready_d;
      track_q    <= track_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (capture) begin
      fifo_mem_q[wr_ptr_q] <= {~fpu_result_tvalid, fpu_result_tdata};
    end
  end

`ifdef ISSUER_STATS_EN
  logic [15:0] stat_issued_q, stat_issued_d;
  logic [15:0] stat_exc_q, stat_exc_d;

  always_comb begin
    stat_issued_d = stat_issued_q + 16'(fire);
    stat_exc_d    = stat_exc_q + 16'(capture & ~fpu_result_tvalid);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      stat_issued_q <= '0;
      stat_exc_q    <= '0;
    end else begin
      stat_issued_q <= stat_issued_d;
      stat_exc_q    <= stat_exc_d;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_exc    = stat_exc_q;
`endif

  a_no_overflow: assert property (@(posedge aclk) disable iff (areset)
    !(capture && !pop && (count_q == CNT_W'(FIFO_DEPTH))));

  a_inflight_range: assert property (@(posedge aclk) disable iff (areset)
    (inflight_q <= IF_W'(LATENCY)));

endmodule

// File: tb/tb_fpu_axis_issuer.sv
// Bench for fpu_axis_issuer: stub FP pipe plus a queue-based reference of issue order, credit and timing.
module tb_fpu_axis_issuer;
  localparam int LAT   = 6;
  localparam int DEPTH = 8;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [31:0] op_tdata = '0;
  logic        op_tvalid = 1'b0;
  logic        op_tready;
  logic [15:0] fa, fb;
  logic        fav, fbv;
  logic [15:0] rdata;
  logic        rvalid;
  logic [15:0] m_tdata;
  logic        m_tuser, m_tvalid;
  logic        m_tready = 1'b0;
`ifdef ISSUER_STATS_EN
  logic [15:0] stat_issued, stat_exc;
`endif

  always #5 aclk = ~aclk;

  fpu_axis_issuer #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .DATA_W(16)) dut (
    .aclk              (aclk),
    .areset            (areset),
    .s_axis_op_tdata   (op_tdata),
    .s_axis_op_tvalid  (op_tvalid),
    .s_axis_op_tready  (op_tready),
    .fpu_a_tdata       (fa),
    .fpu_b_tdata       (fb),
    .fpu_a_tvalid      (fav),
    .fpu_b_tvalid      (fbv),
    .fpu_result_tdata  (rdata),
    .fpu_result_tvalid (rvalid),
    .m_axis_res_tdata  (m_tdata),
    .m_axis_res_tuser  (m_tuser),
    .m_axis_res_tvalid (m_tvalid),
    .m_axis_res_tready (m_tready)
`ifdef ISSUER_STATS_EN
    ,
    .stat_issued       (stat_issued),
    .stat_exc          (stat_exc)
`endif
  );

  int total = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Stub pipe arithmetic: {exception, result}. Inf/NaN operands raise the exception.
  function automatic logic [16:0] pipe_fn(input logic [15:0] a, input logic [15:0] b);
    if (a[14:10] == 5'h1f || b[14:10] == 5'h1f) return {1'b1, 16'h7E00};
    if (a == 16'h4000 && b == 16'h3C00) return {1'b0, 16'h3C00};
    return {1'b0, a ^ {b[7:0], b[15:8]}};
  endfunction

  // Stub pipe: LAT-deep, junk on the result bus whenever no op is due.
  logic [17:0] pipe_q [LAT];
  logic [15:0] junk_q;
  logic        junk_v_q;
  always @(posedge aclk) begin
    pipe_q[0] <= {fav & fbv, pipe_fn(fa, fb)};
    for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
    junk_q   <= 16'($urandom);
    junk_v_q <= 1'($urandom);
  end
  assign rdata  = pipe_q[LAT-1][17] ? pipe_q[LAT-1][15:0] : junk_q;
  assign rvalid = pipe_q[LAT-1][17] ? ~pipe_q[LAT-1][16] : junk_v_q;

  // Reference: every accepted pair is owed one result, visible LAT+1 cycles after issue, in order.
  typedef struct {
    logic [16:0] res;
    int          rdy;
  } exp_t;
  exp_t q[$];
  int   exc_pend[$];
  int   cyc = 0;
  int   exp_issued = 0;
  int   exp_exc = 0;
  bit   prev_rst = 1'b1;
  bit   started = 1'b0;
  logic exp_tready, exp_mv;

  always @(negedge aclk) begin
    cyc++;
    exp_tready = 1'b0;
    exp_mv     = 1'b0;
    if (started) begin
      exp_tready = !prev_rst && (q.size() < DEPTH);
      exp_mv     = (q.size() > 0) && (q[0].rdy <= cyc);
      chk("op_tready", 32'(op_tready), 32'(exp_tready));
      chk("res_tvalid", 32'(m_tvalid), 32'(exp_mv));
      if (exp_mv) begin
        chk("res_tdata", 32'(m_tdata), 32'(q[0].res[15:0]));
        chk("res_tuser", 32'(m_tuser), 32'(q[0].res[16]));
      end else begin
        chk("idle_tdata", 32'(m_tdata), 32'h0);
        chk("idle_tuser", 32'(m_tuser), 32'h0);
      end
      chk("fpu_a_tvalid", 32'(fav), 32'(op_tvalid & exp_tready));
      chk("fpu_b_tvalid", 32'(fbv), 32'(op_tvalid & exp_tready));
      chk("fpu_ab_tdata", {fa, fb}, op_tdata);
`ifdef ISSUER_STATS_EN
      while (exc_pend.size() > 0 && exc_pend[0] <= cyc) begin
        void'(exc_pend.pop_front());
        exp_exc++;
      end
      chk("stat_issued", 32'(stat_issued), 32'(16'(exp_issued)));
      chk("stat_exc", 32'(stat_exc), 32'(16'(exp_exc)));
`endif
    end
    if (areset) begin
      q.delete();
      exc_pend.delete();
      exp_issued = 0;
      exp_exc    = 0;
      started    = 1'b1;
    end else if (started) begin
      if (exp_mv && m_tready) void'(q.pop_front());
      if (op_tvalid && exp_tready) begin
        exp_t e;
        e.res = pipe_fn(op_tdata[31:16], op_tdata[15:0]);
        e.rdy = cyc + LAT + 1;
        q.push_back(e);
        exp_issued++;
        if (e.res[16]) exc_pend.push_back(cyc + LAT + 1);
      end
    end
    prev_rst = areset;
  end

  task automatic drive(input logic v, input logic [31:0] d);
    @(posedge aclk);
    #1;
    op_tvalid = v;
    op_tdata  = d;
  endtask

  function automatic logic [31:0] rand_op(input bit allow_exc);
    logic [31:0] d;
    d = $urandom;
    if (!allow_exc) begin
      d[30] = 1'b0;
      d[14] = 1'b0;
    end else if ($urandom_range(0, 7) == 0) begin
      d[31:16] = 16'h7C00;
    end
    return d;
  endfunction

  initial begin
    int  fires, fires2, seen, drops;
    bit  got;

    // Reset state
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_op_tready", 32'(op_tready), 32'h0);
    chk("rst_res_tvalid", 32'(m_tvalid), 32'h0);
    chk("rst_res_tdata", 32'(m_tdata), 32'h0);
    chk("rst_res_tuser", 32'(m_tuser), 32'h0);
    chk("rst_fpu_tvalid", 32'(fav | fbv), 32'h0);
    @(posedge aclk); #1 areset = 1'b0;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("post_rst_tready", 32'(op_tready), 32'h1);

    // Test 1: single op, latency LAT+1
    drive(1'b1, 32'h4000_3C00);
    m_tready = 1'b1;
    @(negedge aclk);
    chk("t1_fire", 32'(op_tready), 32'h1);
    drive(1'b0, 32'h0);
    got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge aclk);
      if (m_tvalid) begin
        got = 1'b1;
        chk("t1_latency", 32'(k), 32'(LAT + 1));
        chk("t1_tdata", 32'(m_tdata), 32'h3C00);
        chk("t1_tuser", 32'(m_tuser), 32'h0);
      end
    end
    if (!got) chk("t1_timeout", 32'h0, 32'h1);
    repeat (3) @(posedge aclk);

    // Reset pulse so the statistics start from zero
    #1 areset = 1'b1;
    @(posedge aclk); #1 areset = 1'b0;
    repeat (2) @(posedge aclk);

    // Test 2: 20 back-to-back pairs
    drops = 0;
    seen  = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, rand_op(1'b0));
      @(negedge aclk);
      if (!op_tready) drops++;
      if (m_tvalid && m_tready) seen++;
    end
    drive(1'b0, 32'h0);
    for (int i = 0; i < 15; i++) begin
      @(negedge aclk);
      if (m_tvalid && m_tready) seen++;
      @(posedge aclk);
    end
    chk("t2_tready_drops", 32'(drops), 32'h0);
    chk("t2_results", 32'(seen), 32'd20);

    // Test 4: exception result
    drive(1'b1, 32'h7C00_7C00);
    drive(1'b0, 32'h0);
    got = 1'b0;
    for (int k = 0; k < 15 && !got; k++) begin
      @(negedge aclk);
      if (m_tvalid) begin
        got = 1'b1;
        chk("t4_tuser", 32'(m_tuser), 32'h1);
      end
    end
    if (!got) chk("t4_timeout", 32'h0, 32'h1);
    repeat (2) @(posedge aclk);
`ifdef ISSUER_STATS_EN
    @(negedge aclk);
    chk("t6_stat_issued", 32'(stat_issued), 32'd21);
    chk("t6_stat_exc", 32'(stat_exc), 32'd1);
`endif

    // Test 3: stalled output, credit stops issue at DEPTH
    m_tready = 1'b0;
    fires = 0;
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, rand_op(1'b0));
      @(negedge aclk);
      if (op_tready) fires++;
    end
    chk("t3_fires", 32'(fires), 32'(DEPTH));
    chk("t3_tready_low", 32'(op_tready), 32'h0);
    chk("t3_res_pending", 32'(m_tvalid), 32'h1);
    @(posedge aclk); #1 m_tready = 1'b1;
    fires2 = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, rand_op(1'b0));
      @(negedge aclk);
      if (op_tready) fires2++;
    end
    chk("t3_resume", 32'(fires2 > 0), 32'h1);
    drive(1'b0, 32'h0);
    repeat (20) @(posedge aclk);

    // Test 5: reset with ops in flight
    drive(1'b1, rand_op(1'b0));
    drive(1'b1, rand_op(1'b0));
    drive(1'b1, rand_op(1'b0));
    areset = 1'b1;
    drive(1'b0, 32'h0);
    areset = 1'b0;
    @(negedge aclk);
    chk("t5_tready_in_rst_cycle", 32'(op_tready), 32'h0);
    @(posedge aclk);
    @(negedge aclk);
    chk("t5_tready_after_rst", 32'(op_tready), 32'h1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      if (m_tvalid) seen++;
    end
    chk("t5_no_result", 32'(seen), 32'h0);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 2) != 0), rand_op(1'b1));
      m_tready = ($urandom_range(0, 3) != 0);
    end
    drive(1'b0, 32'h0);
    m_tready = 1'b1;
    repeat (30) @(posedge aclk);
    @(negedge aclk);
    chk("final_res_tvalid", 32'(m_tvalid), 32'h0);
    chk("final_op_tready", 32'(op_tready), 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
